data_access_fsm: RTL and testbench
==================================

# data_access_fsm

Memory operand access sequencer for the v6502 core. Once address generation has produced an effective address, this block performs the data-bus side of the instruction: a single read, a single write, or a 6502-style read-modify-write with the dummy write-back. Address generation reads operand bytes in. This block is its counterpart and drives operand reads and stores on the same address/data bus. It sits between the effective-address path and the ALU.

## Interface
- No parameters.
- Clock is i_clk. Reset is i_rst_n, asynchronous, active-low.
- i_clk  in  1  core clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  request strobe. Sampled only in IDLE.
- i_op  in  2  operation, sampled with i_start: 0 READ, 1 WRITE, 2 RMW, 3 NOP.
- i_eff_addr  in  16  effective address, sampled with i_start.
- i_wdata  in  8  store data for WRITE, sampled with i_start.
- i_data  in  8  data bus input from memory.
- i_mdata  in  8  modified value from the ALU, used by RMW.
- o_addr  out  16  address bus.
- o_data  out  8  data bus output. Valid only while o_we=1.
- o_we  out  1  write enable.
- o_rdata  out  8  latched read operand.
- o_modify  out  1  high during the RMW dummy-write cycle. Requests i_mdata.
- o_busy  out  1  high whenever the state is not IDLE.
- o_done  out  1  one-cycle completion pulse.

## Operation
- State register states: IDLE, RD, DW (dummy write), WR. Encoding is free.
- Internal registers: op (2b), addr (16b), wdata (8b).
- IDLE with i_start=1 captures the request:
  - op<=i_op, addr<=i_eff_addr.
  - wdata<=i_wdata if i_op=WRITE, else unchanged.
  - Next state: READ→RD, RMW→RD, WRITE→WR, NOP→IDLE. NOP sets the done flag.
- RD:
  - o_addr=addr, o_we=0.
  - At the end of the cycle, o_rdata<=i_data.
  - Next state: RMW→DW; READ→IDLE with done.
- DW:
  - o_addr=addr, o_we=1, o_data=o_rdata (the original value), o_modify=1.
  - At the end of the cycle, wdata<=i_mdata.
  - Next state: WR.
- WR:
  - o_addr=addr, o_we=1, o_data=wdata.
  - Next state: IDLE with done.
- o_done is a register set on each transition into IDLE that completes an operation, including NOP. It is cleared after one cycle.
- i_start while busy is ignored. No queuing.
- i_start in the same cycle as o_done=1 is accepted, so back-to-back requests work.
- In IDLE:
  - o_addr holds the last addr (the captured register, not i_eff_addr).
  - o_we=0, o_modify=0.
  - o_data equals the wdata register.
- o_rdata holds its value until the next RD cycle. WRITE and NOP leave it untouched.
- The address is never incremented. No page-cross or index arithmetic is done here.

## Timing
- All outputs are registered state or decode of state/registers. There are no combinational paths from inputs to outputs.
- Reset values: state IDLE, addr 16'h0000, wdata 8'h00, o_rdata 8'h00, o_we 0, o_modify 0, o_busy 0, o_done 0.
- Latency, counted with the i_start cycle as cycle 0:
  - READ: bus read in cycle 1; o_done=1 and o_rdata valid in cycle 2.
  - WRITE: write in cycle 1; o_done in cycle 2.
  - RMW: read in cycle 1, dummy write in cycle 2, final write in cycle 3; o_done in cycle 4.
  - NOP: o_done in cycle 1, with no bus activity.
- Throughput with back-to-back requests: READ/WRITE every 2 cycles, RMW every 4.
- i_data must be stable at the rising edge that ends RD. i_mdata must be stable at the rising edge that ends DW.
- o_busy is high exactly during RD, DW and WR cycles.
- Asynchronous reset mid-operation:
  - All outputs return to their reset values immediately, including o_we=0.
  - The in-flight operation is abandoned. No o_done is produced.

## Test plan
- Reset: assert i_rst_n=0 while in DW → o_we and o_modify drop to 0 immediately and o_busy=0. After release, o_addr=0000, o_rdata=00, and no o_done pulse follows.
- READ: i_start, op=0, addr=1234, memory[1234]=5A → cycle 1 o_addr=1234 with o_we=0. Cycle 2 o_done=1 and o_rdata=5A. o_done is low in cycle 3.
- WRITE: i_start, op=1, addr=00FF, wdata=C3 → cycle 1 o_we=1, o_addr=00FF, o_data=C3. Cycle 2 o_done=1. Memory[00FF]=C3.
- RMW: op=2, addr=0200, memory=41, i_mdata=82 (the ALU's ASL result) → the following cycle sequence:
  - cycle 1: read 41
  - cycle 2: o_we=1, o_data=41, o_modify=1
  - cycle 3: o_we=1, o_data=82
  - cycle 4: o_done=1
  - Final memory[0200]=82.
- Back-to-back and ignore:
  - READ, then WRITE issued in the o_done cycle → the WRITE bus cycle occurs the next cycle.
  - An i_start pulsed during the busy RMW cycles 1–3 produces no extra access.
- NOP: op=3, addr=ABCD → o_done=1 in cycle 1, o_we stays 0, and o_addr shows ABCD from cycle 1.

Source files
------------

// File: rtl/data_access_fsm.sv
// data_access_fsm: data-bus side of a memory operand access.
// Sequences READ, WRITE, RMW (with dummy write-back) and NOP.
module data_access_fsm (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [15:0] i_eff_addr,
    input  logic [7:0]  i_wdata,
    input  logic [7:0]  i_data,
    input  logic [7:0]  i_mdata,
    output logic [15:0] o_addr,
    output logic [7:0]  o_data,
    output logic        o_we,
    output logic [7:0]  o_rdata,
    output logic        o_modify,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_RMW   = 2'd2;
    localparam logic [1:0] OP_NOP   = 2'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_DW   = 2'd2;
    localparam logic [1:0] S_WR   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        done_q, done_d;

    // Next-state and register update decode.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    op_d   = i_op;
                    addr_d = i_eff_addr;
                    if (i_op == OP_WRITE) begin
                        wdata_d = i_wdata;
                    end
                    unique case (i_op)
                        OP_READ:  state_d = S_RD;
                        OP_RMW:   state_d = S_RD;
                        OP_WRITE: state_d = S_WR;
                        OP_NOP: begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
            S_RD: begin
                rdata_d = i_data;
                if (op_q == OP_RMW) begin
                    state_d = S_DW;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_DW: begin
                wdata_d = i_mdata;
                state_d = S_WR;
            end
            S_WR: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        endcase
    end

    // State and operand registers; reset abandons any operation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_READ;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    // Bus outputs decoded from state; the dummy write returns the original value.
    always_comb begin
        o_addr   = addr_q;
        o_we     = (state_q == S_DW) || (state_q == S_WR);
        o_data   = (state_q == S_DW) ? rdata_q : wdata_q;
        o_modify = (state_q == S_DW);
        o_busy   = (state_q != S_IDLE);
        o_rdata  = rdata_q;
        o_done   = done_q;
    end

endmodule

// File: tb/tb_data_access_fsm.sv
// tb_data_access_fsm: directed bench for data_access_fsm
// with a simple byte memory on the bus.
module tb_data_access_fsm;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [1:0]  i_op;
    logic [15:0] i_eff_addr;
    logic [7:0]  i_wdata;
    logic [7:0]  i_data;
    logic [7:0]  i_mdata;
    logic [15:0] o_addr;
    logic [7:0]  o_data;
    logic        o_we;
    logic [7:0]  o_rdata;
    logic        o_modify;
    logic        o_busy;
    logic        o_done;

    logic [7:0] mem [0:65535];
    int total = 0;
    int bad   = 0;

    data_access_fsm dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_eff_addr (i_eff_addr),
        .i_wdata    (i_wdata),
        .i_data     (i_data),
        .i_mdata    (i_mdata),
        .o_addr     (o_addr),
        .o_data     (o_data),
        .o_we       (o_we),
        .o_rdata    (o_rdata),
        .o_modify   (o_modify),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    assign i_data = mem[o_addr];

    always @(posedge i_clk) begin
        if (o_we) mem[o_addr] <= o_data;
    end

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic req(input logic [1:0] op, input logic [15:0] a,
                       input logic [7:0] wd);
        i_op       = op;
        i_eff_addr = a;
        i_wdata    = wd;
        i_start    = 1'b1;
        step();
        i_start    = 1'b0;
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_start    = 1'b0;
        i_op       = 2'd0;
        i_eff_addr = 16'h0;
        i_wdata    = 8'h0;
        i_mdata    = 8'h0;
        mem[16'h1234] = 8'h5A;
        mem[16'h00FF] = 8'h00;
        mem[16'h0200] = 8'h41;
        mem[16'h0210] = 8'h10;
        mem[16'h0300] = 8'h00;
        mem[16'h0400] = 8'h00;
        mem[16'h0500] = 8'h33;
        step();
        step();
        chk("rst_addr", o_addr, 16'h0000);
        chk("rst_rdata", 16'(o_rdata), 16'h00);
        chk("rst_data", 16'(o_data), 16'h00);
        chk("rst_we", 16'(o_we), 16'd0);
        chk("rst_busy", 16'(o_busy), 16'd0);
        chk("rst_done", 16'(o_done), 16'd0);
        i_rst_n = 1'b1;
        step();

        // READ
        req(2'd0, 16'h1234, 8'h00);
        chk("rd_c1_addr", o_addr, 16'h1234);
        chk("rd_c1_we", 16'(o_we), 16'd0);
        chk("rd_c1_busy", 16'(o_busy), 16'd1);
        chk("rd_c1_done", 16'(o_done), 16'd0);
        step();
        chk("rd_c2_done", 16'(o_done), 16'd1);
        chk("rd_c2_rdata", 16'(o_rdata), 16'h5A);
        chk("rd_c2_busy", 16'(o_busy), 16'd0);
        step();
        chk("rd_c3_done", 16'(o_done), 16'd0);

        // WRITE
        req(2'd1, 16'h00FF, 8'hC3);
        chk("wr_c1_we", 16'(o_we), 16'd1);
        chk("wr_c1_addr", o_addr, 16'h00FF);
        chk("wr_c1_data", 16'(o_data), 16'hC3);
        chk("wr_c1_mod", 16'(o_modify), 16'd0);
        step();
        chk("wr_c2_done", 16'(o_done), 16'd1);
        chk("wr_c2_we", 16'(o_we), 16'd0);
        chk("wr_mem", 16'(mem[16'h00FF]), 16'hC3);
        chk("wr_rdata_kept", 16'(o_rdata), 16'h5A);
        step();

        // RMW
        i_mdata = 8'h82;
        req(2'd2, 16'h0200, 8'h00);
        chk("rmw_c1_addr", o_addr, 16'h0200);
        chk("rmw_c1_we", 16'(o_we), 16'd0);
        chk("rmw_c1_mod", 16'(o_modify), 16'd0);
        step();
        chk("rmw_c2_we", 16'(o_we), 16'd1);
        chk("rmw_c2_data", 16'(o_data), 16'h41);
        chk("rmw_c2_mod", 16'(o_modify), 16'd1);
        step();
        chk("rmw_c3_we", 16'(o_we), 16'd1);
        chk("rmw_c3_data", 16'(o_data), 16'h82);
        chk("rmw_c3_mod", 16'(o_modify), 16'd0);
        chk("rmw_c3_done", 16'(o_done), 16'd0);
        step();
        chk("rmw_c4_done", 16'(o_done), 16'd1);
        chk("rmw_c4_busy", 16'(o_busy), 16'd0);
        chk("rmw_mem", 16'(mem[16'h0200]), 16'h82);
        step();

        // RMW with ignored start pulses in cycles 1-3
        i_mdata = 8'h20;
        req(2'd2, 16'h0210, 8'h00);
        for (int k = 0; k < 3; k++) begin
            i_op       = 2'd1;
            i_eff_addr = 16'h0300;
            i_wdata    = 8'h77;
            i_start    = 1'b1;
            if (k == 2) chk("ign_c3_data", 16'(o_data), 16'h20);
            step();
        end
        i_start = 1'b0;
        chk("ign_c4_done", 16'(o_done), 16'd1);
        chk("ign_c4_addr", o_addr, 16'h0210);
        step();
        chk("ign_c5_busy", 16'(o_busy), 16'd0);
        chk("ign_c5_we", 16'(o_we), 16'd0);
        chk("ign_mem_rmw", 16'(mem[16'h0210]), 16'h20);
        chk("ign_mem_x", 16'(mem[16'h0300]), 16'h00);

        // READ then WRITE in the done cycle
        req(2'd0, 16'h1234, 8'h00);
        step();
        chk("b2b_rd_done", 16'(o_done), 16'd1);
        req(2'd1, 16'h0400, 8'h99);
        chk("b2b_wr_we", 16'(o_we), 16'd1);
        chk("b2b_wr_addr", o_addr, 16'h0400);
        chk("b2b_wr_data", 16'(o_data), 16'h99);
        step();
        chk("b2b_wr_done", 16'(o_done), 16'd1);
        chk("b2b_mem", 16'(mem[16'h0400]), 16'h99);
        step();

        // NOP
        req(2'd3, 16'hABCD, 8'h11);
        chk("nop_c1_done", 16'(o_done), 16'd1);
        chk("nop_c1_we", 16'(o_we), 16'd0);
        chk("nop_c1_addr", o_addr, 16'hABCD);
        chk("nop_c1_busy", 16'(o_busy), 16'd0);
        chk("nop_c1_data", 16'(o_data), 16'h99);
        step();
        chk("nop_c2_done", 16'(o_done), 16'd0);

        // Reset asserted during the dummy write
        i_mdata = 8'h66;
        req(2'd2, 16'h0500, 8'h00);
        step();
        chk("mr_dw_mod", 16'(o_modify), 16'd1);
        i_rst_n = 1'b0;
        #1;
        chk("mr_we", 16'(o_we), 16'd0);
        chk("mr_mod", 16'(o_modify), 16'd0);
        chk("mr_busy", 16'(o_busy), 16'd0);
        #2;
        i_rst_n = 1'b1;
        #1;
        chk("mr_addr", o_addr, 16'h0000);
        chk("mr_rdata", 16'(o_rdata), 16'h00);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mr_no_done", 16'(o_done), 16'd0);
            chk("mr_idle", 16'(o_busy), 16'd0);
        end
        chk("mr_mem", 16'(mem[16'h0500]), 16'h33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
